// File: rtl/boron_pkg.sv
// Shared definitions for the BORON encryption scheduler.
//   BLOCK_W / KEY_W / NUM_ROUNDS : BORON core geometry (64-bit block, 80-bit key, 25 rounds)
//   sched_state_e                : scheduler FSM states, 2-bit encoding
package boron_pkg;

  localparam int unsigned BLOCK_W    = 64;
  localparam int unsigned KEY_W      = 80;
  localparam int unsigned NUM_ROUNDS = 25;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLaunch  = 2'd1,
    StWait    = 2'd2,
    StRespond = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : highest-priority index; search order is ptr, ptr+1, ... (mod NUM_REQ)
//   grant : one-hot winner, all zero when no request
//   idx   : winner index (0 when no request)
//   any   : at least one request present
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int unsigned      pos;
  logic [IDX_W-1:0] pos_idx;
  logic             found;

  always_comb begin
    grant   = '0;
    idx     = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos     = (int'(ptr) + k) % NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (!found && req[pos_idx]) begin
        found          = 1'b1;
        grant[pos_idx] = 1'b1;
        idx            = pos_idx;
      end
    end
    any = found;
  end

endmodule

// File: rtl/boron_enc_scheduler.sv
// Shares one BORON encryption core among NUM_REQ requesters.
//   req_valid/req_ready/req_plain_text/req_key : per-requester job input (round-robin accept)
//   rsp_valid/rsp_ready/rsp_cipher_text/rsp_error : result back to the granted requester
//   core_start/core_plain_text/core_key         : launch interface to the core
//   core_done/core_cipher_text                  : completion from the core
//   busy                                        : a job is in flight (state != IDLE)
// A watchdog in WAIT returns an error response if the core never signals done.
module boron_enc_scheduler
  import boron_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [BLOCK_W*NUM_REQ-1:0] req_plain_text,
  input  logic [KEY_W*NUM_REQ-1:0]   req_key,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [BLOCK_W-1:0]         rsp_cipher_text,
  output logic                       rsp_error,
  output logic                       core_start,
  output logic [BLOCK_W-1:0]         core_plain_text,
  output logic [KEY_W-1:0]           core_key,
  input  logic                       core_done,
  input  logic [BLOCK_W-1:0]         core_cipher_text,
  output logic                       busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);

  sched_state_e       state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [BLOCK_W-1:0] pt_q, pt_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [BLOCK_W-1:0] cipher_q, cipher_d;
  logic               err_q, err_d;
  logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [NUM_REQ-1:0] grant_oh;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    pt_d     = pt_q;
    key_d    = key_q;
    cipher_d = cipher_q;
    err_d    = err_q;
    wd_cnt_d = wd_cnt_q;

    unique case (state_q)
      StIdle: begin
        // The arbiter only grants valid requesters, so any grant is an accept.
        if (arb_any) begin
          pt_d    = req_plain_text[BLOCK_W*arb_idx +: BLOCK_W];
          key_d   = req_key[KEY_W*arb_idx +: KEY_W];
          grant_d = arb_idx;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        wd_cnt_d = '0;
        state_d  = StWait;
      end
      StWait: begin
        // Done takes priority over a watchdog hit in the same cycle.
        if (core_done) begin
          cipher_d = core_cipher_text;
          err_d    = 1'b0;
          state_d  = StRespond;
        end else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          cipher_d = '0;
          err_d    = 1'b1;
          state_d  = StRespond;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      StRespond: begin
        if (rsp_ready[grant_q]) begin
          rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      pt_q     <= '0;
      key_q    <= '0;
      cipher_q <= '0;
      err_q    <= 1'b0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      pt_q     <= pt_d;
      key_q    <= key_d;
      cipher_q <= cipher_d;
      err_q    <= err_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign req_ready       = (state_q == StIdle) ? arb_grant : '0;
  assign rsp_valid       = (state_q == StRespond) ? grant_oh : '0;
  assign rsp_cipher_text = cipher_q;
  assign rsp_error       = err_q;
  assign core_start      = (state_q == StLaunch);
  assign core_plain_text = pt_q;
  assign core_key        = key_q;
  assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_boron_enc_scheduler.sv
// Directed testbench for boron_enc_scheduler with a behavioural core model.
// The core model raises core_done LAT cycles after the first WAIT cycle (LAT=0: never).
module tb_boron_enc_scheduler;

  localparam int unsigned N = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [64*N-1:0] req_plain_text;
  logic [80*N-1:0] req_key;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [63:0]    rsp_cipher_text;
  logic           rsp_error;
  logic           core_start;
  logic [63:0]    core_plain_text;
  logic [79:0]    core_key;
  logic           core_done;
  logic [63:0]    core_cipher_text;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int lat    = 0;
  int start_cnt = 0;

  logic [63:0] pt  [N];
  logic [79:0] key [N];

  boron_enc_scheduler #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_plain_text   (req_plain_text),
    .req_key          (req_key),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_cipher_text  (rsp_cipher_text),
    .rsp_error        (rsp_error),
    .core_start       (core_start),
    .core_plain_text  (core_plain_text),
    .core_key         (core_key),
    .core_done        (core_done),
    .core_cipher_text (core_cipher_text),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] enc(input logic [63:0] p, input logic [79:0] k);
    return {p[31:0], p[63:32]} ^ k[63:0] ^ {48'h0, k[79:64]} ^ 64'h0B0B_0B0B_0B0B_0B0B;
  endfunction

  // Behavioural core: captures inputs on start, pulses done with its result later.
  logic        m_active;
  int          m_cnt;
  logic [63:0] m_pt;
  logic [79:0] m_key;

  always @(posedge clk) begin
    core_done        <= 1'b0;
    core_cipher_text <= '1;
    if (reset) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
    end else if (core_start) begin
      m_active <= (lat != 0);
      m_cnt    <= 1;
      m_pt     <= core_plain_text;
      m_key    <= core_key;
    end else if (m_active) begin
      if (m_cnt == lat) begin
        core_done        <= 1'b1;
        core_cipher_text <= enc(m_pt, m_key);
        m_active         <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(posedge clk) if (core_start) start_cnt <= start_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until a response appears; bounded so a stuck DUT cannot hang the run.
  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid == '0 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int n;
  int s0;

  initial begin
    pt[0] = 64'h0123_4567_89AB_CDEF;  key[0] = 80'h0;
    pt[1] = 64'hFEDC_BA98_7654_3210;  key[1] = 80'h1111_2222_3333_4444_5555;
    pt[2] = 64'hDEAD_BEEF_CAFE_F00D;  key[2] = 80'hA5A5_5A5A_0F0F_F0F0_1234;
    pt[3] = 64'h0000_0000_0000_0000;  key[3] = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    req_plain_text = {pt[3], pt[2], pt[1], pt[0]};
    req_key        = {key[3], key[2], key[1], key[0]};
    req_valid = '0;
    rsp_ready = '0;
    reset     = 1'b0;
    #1;
    do_reset();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_cipher", rsp_cipher_text, 0);
    chk("rst_core_pt", core_plain_text, 0);
    chk("rst_core_key", core_key, 0);

    // 1: single job on requester 0
    lat = 3;
    s0  = start_cnt;
    req_valid = 4'b0001;
    #1;
    chk("t1_req_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("t1_core_start", core_start, 1);
    chk("t1_busy", busy, 1);
    chk("t1_req_ready_launch", req_ready, 0);
    chk("t1_core_pt", core_plain_text, pt[0]);
    chk("t1_core_key", core_key, key[0]);
    wait_rsp(n);
    chk("t1_latency", n, 5);
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_cipher", rsp_cipher_text, enc(pt[0], key[0]));
    chk("t1_error", rsp_error, 0);
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    chk("t1_idle", busy, 0);
    chk("t1_rsp_clear", rsp_valid, 0);
    chk("t1_one_start", start_cnt - s0, 1);

    // 2: contention, all requesters held valid
    do_reset();
    lat = 2;
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_rsp(n);
      chk($sformatf("t2_grant%0d", g), rsp_valid, 4'b0001 << (g % 4));
      chk($sformatf("t2_cipher%0d", g), rsp_cipher_text, enc(pt[g % 4], key[g % 4]));
      tick();
    end
    req_valid = '0;
    rsp_ready = '0;
    // rr_ptr is now 1

    // 3: backpressure on requester 1; other rsp_ready bits must be ignored
    lat = 5;
    req_valid = 4'b0010;
    #1;
    chk("t3_req_ready", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1111;
    wait_rsp(n);
    rsp_ready = 4'b1101;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("t3_hold_valid%0d", c), rsp_valid, 4'b0010);
      chk($sformatf("t3_hold_cipher%0d", c), rsp_cipher_text, enc(pt[1], key[1]));
      chk($sformatf("t3_req_ready%0d", c), req_ready, 0);
      tick();
    end
    rsp_ready = 4'b0010;
    tick();
    rsp_ready = '0;
    chk("t3_idle", busy, 0);
    chk("t3_rsp_clear", rsp_valid, 0);
    req_valid = '0;
    // rr_ptr is now 2

    // 4: timeout on requester 3, core never finishes
    lat = 0;
    req_valid = 4'b1000;
    #1;
    tick();
    req_valid = '0;
    chk("t4_core_start", core_start, 1);
    wait_rsp(n);
    chk("t4_latency", n, 65);
    chk("t4_rsp_valid", rsp_valid, 4'b1000);
    chk("t4_error", rsp_error, 1);
    chk("t4_cipher", rsp_cipher_text, 0);
    rsp_ready = 4'b1000;
    tick();
    rsp_ready = '0;
    chk("t4_idle", busy, 0);

    // 5: done on the last WAIT cycle (requester 0)
    lat = 63;
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = '0;
    wait_rsp(n);
    chk("t5_latency", n, 65);
    chk("t5_rsp_valid", rsp_valid, 4'b0001);
    chk("t5_error", rsp_error, 0);
    chk("t5_cipher", rsp_cipher_text, enc(pt[0], key[0]));
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;

    // 6: reset during WAIT, then a fresh job on requester 2
    lat = 0;
    req_valid = 4'b0010;
    #1;
    tick();
    req_valid = '0;
    repeat (5) tick();
    chk("t6_busy_wait", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_core_start", core_start, 0);
    req_valid = 4'b1111;
    #1;
    chk("t6_rr_ptr0", req_ready, 4'b0001);
    req_valid = 4'b0100;
    #1;
    chk("t6_req_ready", req_ready, 4'b0100);
    lat = 4;
    tick();
    req_valid = '0;
    chk("t6_launch", core_start, 1);
    wait_rsp(n);
    chk("t6_rsp", rsp_valid, 4'b0100);
    chk("t6_error", rsp_error, 0);
    chk("t6_cipher", rsp_cipher_text, enc(pt[2], key[2]));
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = '0;
    chk("t6_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
